vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL provide parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 The block SHALL provide parameter H_FP, default 40, horizontal front porch in pixels.
REQ-003 The block SHALL provide parameter H_SYNC, default 128, hsync width in pixels.
REQ-004 The block SHALL provide parameter H_BP, default 88, horizontal back porch in pixels; line total is 1056.
REQ-005 The block SHALL provide parameter V_ACTIVE, default 600, visible lines per frame.
REQ-006 The block SHALL provide parameters V_FP, V_SYNC and V_BP, defaults 1, 4 and 23, in lines; frame total is 628.
REQ-007 The block SHALL have port pclk, input, 1 bit, the single pixel clock; all logic is on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-009 The block SHALL have port en, input, 1 bit, the pixel advance enable.
REQ-010 The block SHALL have port hcount_out, output, 11 bits, the horizontal pixel index.
REQ-011 The block SHALL have ports hsync_out and hblnk_out, outputs, 1 bit each, horizontal sync and horizontal blank.
REQ-012 The block SHALL have port vcount_out, output, 11 bits, the line index.
REQ-013 The block SHALL have ports vsync_out and vblnk_out, outputs, 1 bit each, vertical sync and vertical blank.
REQ-014 The block SHALL have port frame_start, output, 1 bit, a one-cycle pulse at pixel (0,0).

Function
REQ-015 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-016 On each pclk edge with rst=0 and en=1, hcount SHALL increment; at 1055 it SHALL wrap to 0 and vcount SHALL increment; when vcount is 627 at that wrap, vcount SHALL wrap to 0.
REQ-017 When en=0, every output SHALL hold its value, and frame_start SHALL be forced to 0.
REQ-018 Sync, blank and frame_start outputs SHALL be decoded from the next counter values, so they are cycle-aligned with hcount_out/vcount_out, with zero relative latency.
REQ-019 hblnk_out SHALL be 1 for hcount 800..1055 and 0 otherwise.
REQ-020 hsync_out SHALL be 1 for hcount 840..967 (active-high) and 0 otherwise.
REQ-021 vblnk_out SHALL be 1 for vcount 600..627 and 0 otherwise.
REQ-022 vsync_out SHALL be 1 for vcount 601..604 (active-high) and 0 otherwise; vsync SHALL change only on the cycle where hcount is 0.
REQ-023 frame_start SHALL be 1 for exactly one enabled cycle, the one where the outputs show hcount=0 and vcount=0, including the first cycle after reset.
REQ-024 All boundaries SHALL be derived from the parameters; counter arithmetic SHALL be 11-bit unsigned, and parameters whose totals exceed 2047 SHALL be rejected at elaboration.

Reset
REQ-025 While rst=1, on the clock edge the outputs SHALL become: hcount_out=0, vcount_out=0, all syncs 0, all blanks 0, frame_start=1.
REQ-026 rst SHALL take priority over en, and a reset asserted mid-frame SHALL restart the frame from (0,0) on the next edge.
REQ-027 The first enabled cycle after rst deasserts SHALL output hcount=1, vcount=0.

Configuration
REQ-028 With macro VGA_TIMING_FRAME_CNT_EN defined, the block SHALL add output frame_cnt (16 bits), reset to 0, incremented on each frame_start after the first, wrapping at 65535 to 0.
REQ-029 Without VGA_TIMING_FRAME_CNT_EN, the frame_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 The default timing constants (800x600@60, 40 MHz) and the 11-bit count width SHALL live in shared package vga_pkg, which is also used by the drawing stages.
REQ-031 The block SHALL contain one sub-module, vga_axis_counter, instanced twice (horizontal and vertical); each instance is a parameterized wrapping counter with enable, providing sync/blank decode and a wrap strobe.

Verification
REQ-032 Reset then 1056 enabled cycles -> hcount goes 1..1055 then 0, vcount steps 0->1, and frame_start is seen exactly once (at reset).
REQ-033 Run 628x1056 cycles -> hsync high for 128 cycles per line starting at hcount=840; vsync high during vcount 601..604; frame_start repeats every 663168 cycles.
REQ-034 Toggle en low for 7 cycles at hcount=1055 -> all outputs frozen; the wrap occurs on the first cycle en returns high.
REQ-035 Assert rst at hcount=500, vcount=300 -> the next edge gives (0,0) with frame_start=1 and syncs and blanks at 0.
REQ-036 With VGA_TIMING_FRAME_CNT_EN defined, run 3 full frames -> frame_cnt=3; without the macro, the build has no frame_cnt port.
REQ-037 Assertion check on every cycle: hblnk=1 whenever hsync=1, vblnk=1 whenever vsync=1, and frame_start implies hcount=0 and vcount=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (800x600@60, 40 MHz pixel clock) and the common counter width.
// Used by the timing generator and by the downstream drawing stages.
package vga_pkg;

   localparam int CNT_W   = 11;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   localparam int PCLK_HZ = 40_000_000;

   localparam int H_ACTIVE_DEF = 800;
   localparam int H_FP_DEF     = 40;
   localparam int H_SYNC_DEF   = 128;
   localparam int H_BP_DEF     = 88;

   localparam int V_ACTIVE_DEF = 600;
   localparam int V_FP_DEF     = 1;
   localparam int V_SYNC_DEF   = 4;
   localparam int V_BP_DEF     = 23;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: wrapping position counter with registered sync/blank decode.
// Sync and blank are decoded from the next count so they line up with the registered count.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = H_ACTIVE_DEF,
   parameter int FP     = H_FP_DEF,
   parameter int SYNC   = H_SYNC_DEF,
   parameter int BP     = H_BP_DEF
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             sync,
   output logic             blnk,
   output logic             wrap
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;

   if ((TOTAL > CNT_MAX) || (TOTAL < 2)) begin : g_bad_total
      $error("vga_axis_counter: axis total %0d outside 2..%0d", TOTAL, CNT_MAX);
   end

   localparam cnt_t LAST    = cnt_t'(TOTAL - 1);
   localparam cnt_t BLNK_LO = cnt_t'(ACTIVE);
   localparam cnt_t SYNC_LO = cnt_t'(ACTIVE + FP);
   localparam cnt_t SYNC_HI = cnt_t'(ACTIVE + FP + SYNC);

   function automatic logic sync_dec(input cnt_t c);
      return (c >= SYNC_LO) && (c < SYNC_HI);
   endfunction

   function automatic logic blnk_dec(input cnt_t c);
      return c >= BLNK_LO;
   endfunction

   cnt_t nxt;

   always_comb begin
      nxt = (count == LAST) ? '0 : count + cnt_t'(1);
   end

   // Strobe seen by the next-slower axis: this axis is about to roll over.
   assign wrap = en && (count == LAST);

   always_ff @(posedge pclk) begin
      if (rst) begin
         count <= '0;
         sync  <= 1'b0;
         blnk  <= 1'b0;
      end else if (en) begin
         count <= nxt;
         sync  <= sync_dec(nxt);
         blnk  <= blnk_dec(nxt);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal/vertical counters, syncs, blanks and frame_start pulse.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame_cnt output.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] hcount_out,
   output logic             hsync_out,
   output logic             hblnk_out,
   output logic [CNT_W-1:0] vcount_out,
   output logic             vsync_out,
   output logic             vblnk_out,
   output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);

   logic h_wrap;
   logic v_wrap;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .pclk  (pclk),
      .rst   (rst),
      .en    (en),
      .count (hcount_out),
      .sync  (hsync_out),
      .blnk  (hblnk_out),
      .wrap  (h_wrap)
   );

   // Vertical axis advances once per completed line.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .pclk  (pclk),
      .rst   (rst),
      .en    (h_wrap),
      .count (vcount_out),
      .sync  (vsync_out),
      .blnk  (vblnk_out),
      .wrap  (v_wrap)
   );

   // v_wrap already implies en, so a stalled cycle never pulses.
   always_ff @(posedge pclk) begin
      if (rst) begin
         frame_start <= 1'b1;
      end else begin
         frame_start <= v_wrap;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   always_ff @(posedge pclk) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (v_wrap) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default-timing instance plus a small-timing instance
// so whole frames fit in a short run; both are checked against a position-based reference model.
module tb_vga_timing_gen;

   typedef struct {
      int h;
      int v;
      bit hs;
      bit hb;
      bit vs;
      bit vb;
      bit fs;
      int fc;
   } exp_t;

   // Index 0: default 800x600 timing, index 1: reduced timing (32 x 20 frame).
   int c_ha[2] = '{800, 16};
   int c_hf[2] = '{40, 4};
   int c_hs[2] = '{128, 8};
   int c_hb[2] = '{88, 4};
   int c_va[2] = '{600, 12};
   int c_vf[2] = '{1, 1};
   int c_vs[2] = '{4, 4};
   int c_vb[2] = '{23, 3};

   logic pclk = 1'b0;
   logic rst  = 1'b0;
   logic en   = 1'b0;

   logic [10:0] h0, v0, h1, v1;
   logic        hs0, hb0, vs0, vb0, fs0;
   logic        hs1, hb1, vs1, vb1, fs1;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] fc0, fc1;
`endif

   always #5 pclk = ~pclk;

   vga_timing_gen dut0 (
      .pclk (pclk), .rst (rst), .en (en),
      .hcount_out (h0), .hsync_out (hs0), .hblnk_out (hb0),
      .vcount_out (v0), .vsync_out (vs0), .vblnk_out (vb0),
      .frame_start (fs0)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt (fc0)
`endif
   );

   vga_timing_gen #(
      .H_ACTIVE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
      .V_ACTIVE (12), .V_FP (1), .V_SYNC (4), .V_BP (3)
   ) dut1 (
      .pclk (pclk), .rst (rst), .en (en),
      .hcount_out (h1), .hsync_out (hs1), .hblnk_out (hb1),
      .vcount_out (v1), .vsync_out (vs1), .vblnk_out (vb1),
      .frame_start (fs1)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt (fc1)
`endif
   );

   exp_t q0[$];
   exp_t q1[$];
   exp_t prev[2];
   int   pos_h[2];
   int   pos_v[2];
   int   fcnt[2];

   int n_pass  = 0;
   int n_total = 0;
   int fs0_seen = 0;

   task automatic chk(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
   endtask

   // Reference: track raster position directly and derive every output from range rules.
   function automatic exp_t model_step(input int k, input bit r, input bit e);
      exp_t x;
      int   htot = c_ha[k] + c_hf[k] + c_hs[k] + c_hb[k];
      int   vtot = c_va[k] + c_vf[k] + c_vs[k] + c_vb[k];
      if (r) begin
         pos_h[k] = 0;
         pos_v[k] = 0;
         fcnt[k]  = 0;
         x.h = 0; x.v = 0; x.hs = 0; x.hb = 0; x.vs = 0; x.vb = 0; x.fs = 1; x.fc = 0;
      end else if (!e) begin
         x = prev[k];
         x.fs = 0;
      end else begin
         pos_h[k] = (pos_h[k] + 1) % htot;
         if (pos_h[k] == 0) pos_v[k] = (pos_v[k] + 1) % vtot;
         x.h  = pos_h[k];
         x.v  = pos_v[k];
         x.hb = (x.h >= c_ha[k]);
         x.hs = (x.h >= c_ha[k] + c_hf[k]) && (x.h < c_ha[k] + c_hf[k] + c_hs[k]);
         x.vb = (x.v >= c_va[k]);
         x.vs = (x.v >= c_va[k] + c_vf[k]) && (x.v < c_va[k] + c_vf[k] + c_vs[k]);
         x.fs = (x.h == 0) && (x.v == 0);
         if (x.fs) fcnt[k] = (fcnt[k] + 1) % 65536;
         x.fc = fcnt[k];
      end
      prev[k] = x;
      return x;
   endfunction

   task automatic drive(input bit r, input bit e);
      @(negedge pclk);
      rst = r;
      en  = e;
      q0.push_back(model_step(0, r, e));
      q1.push_back(model_step(1, r, e));
   endtask

   task automatic check_out(input int k, input exp_t x, input int h, input int v,
                            input bit hs, input bit hb, input bit vs, input bit vb,
                            input bit fs, input int fc);
      chk($sformatf("i%0d_hcount", k), h, x.h);
      chk($sformatf("i%0d_vcount", k), v, x.v);
      chk($sformatf("i%0d_hsync", k), int'(hs), int'(x.hs));
      chk($sformatf("i%0d_hblnk", k), int'(hb), int'(x.hb));
      chk($sformatf("i%0d_vsync", k), int'(vs), int'(x.vs));
      chk($sformatf("i%0d_vblnk", k), int'(vb), int'(x.vb));
      chk($sformatf("i%0d_frame_start", k), int'(fs), int'(x.fs));
      chk($sformatf("i%0d_hsync_outside_hblnk", k), int'(hs && !hb), 0);
      chk($sformatf("i%0d_vsync_outside_vblnk", k), int'(vs && !vb), 0);
      chk($sformatf("i%0d_fs_not_origin", k), int'(fs && (h != 0 || v != 0)), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk($sformatf("i%0d_frame_cnt", k), fc, x.fc);
`else
      if (fc != 0) $display("note: unexpected frame count argument %0d", fc);
`endif
   endtask

   // Monitor: outputs are presented every cycle, so pop one expectation per edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge pclk);
         #1;
         if (fs0 === 1'b1) fs0_seen++;
         if (q0.size() > 0) begin
            x = q0.pop_front();
`ifdef VGA_TIMING_FRAME_CNT_EN
            check_out(0, x, int'(h0), int'(v0), hs0, hb0, vs0, vb0, fs0, int'(fc0));
`else
            check_out(0, x, int'(h0), int'(v0), hs0, hb0, vs0, vb0, fs0, 0);
`endif
         end
         if (q1.size() > 0) begin
            x = q1.pop_front();
`ifdef VGA_TIMING_FRAME_CNT_EN
            check_out(1, x, int'(h1), int'(v1), hs1, hb1, vs1, vb1, fs1, int'(fc1));
`else
            check_out(1, x, int'(h1), int'(v1), hs1, hb1, vs1, vb1, fs1, 0);
`endif
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset, including rst held against en=1.
      drive(1, 0);
      drive(1, 1);
      @(posedge pclk);
      #2;
      fs0_seen = 0;
      drive(1, 0);

      // One full default line: h runs 1..1055 then 0, v steps to 1.
      for (int i = 0; i < 1056; i++) drive(0, 1);
      @(posedge pclk);
      #2;
      chk("fs_once_first_line", fs0_seen, 1);

      // Park on h=1055, stall 7 cycles, then wrap on resume.
      for (int i = 0; i < 1055; i++) drive(0, 1);
      for (int i = 0; i < 7; i++) drive(0, 0);
      for (int i = 0; i < 4; i++) drive(0, 1);

      // Random enable pattern, mostly advancing.
      for (int i = 0; i < 3000; i++) drive(0, ($urandom_range(0, 7) != 0));

      // Mid-line reset on the default instance.
      for (int n = 0; n < 1100 && pos_h[0] != 500; n++) drive(0, 1);
      drive(1, 1);
      for (int i = 0; i < 20; i++) drive(0, 1);

      // Mid-frame reset on the reduced instance, asserted while en is low.
      for (int n = 0; n < 700 && !(pos_h[1] == 10 && pos_v[1] == 6); n++) drive(0, 1);
      drive(1, 0);

      // Three full reduced frames after reset.
      for (int i = 0; i < 3 * 640; i++) drive(0, 1);
      @(posedge pclk);
      #2;
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("frame_cnt_after_3_frames", int'(fc1), 3);
`endif
      chk("small_origin_after_3_frames", int'(h1) + int'(v1), 0);
      chk("scoreboard_drained", q0.size() + q1.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
